// File: rtl/adder_arb_pkg.sv
// ============================================================================
// Module   : adder_arb_pkg
// Purpose  : Shared types and constants for the round-robin adder arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package adder_arb_pkg;

    localparam int NIB = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int clog2_int(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/Ripple_Carry_Adder.sv
// ============================================================================
// Module   : Ripple_Carry_Adder
// Purpose  : Plain ripple-carry adder built from one full-adder cell per bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module Ripple_Carry_Adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            assign sum[g]       = a[g] ^ b[g] ^ w_carry[g];
            assign w_carry[g+1] = (a[g] & b[g]) | (w_carry[g] & (a[g] ^ b[g]));
        end
    endgenerate

    assign cout = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin pick: first set request at or above
//            rr_ptr, wrapping modulo NREQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            found,
    output logic [IDW-1:0]  index
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;

    // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit wins.
    assign w_dbl = {req, req} >> rr_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
    end

    assign w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
    assign found = |req;
    assign index = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                             : w_sum[IDW-1:0];

endmodule

`default_nettype wire

// File: rtl/adder_rr_arbiter.sv
// ============================================================================
// Module   : adder_rr_arbiter
// Purpose  : Round-robin sharing of one 4-bit ripple adder between NREQ
//            multi-beat requesters. Optional macro ADDER_ARB_OVF_EN adds res_ovf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NIB*NREQ-1:0] req_a,
    input  logic [NIB*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]     req_cin,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NIB-1:0]      res_sum,
    output logic                res_cout,
    output logic [IDW-1:0]      res_id,
    output logic                res_last
`ifdef ADDER_ARB_OVF_EN
   ,output logic                res_ovf
`endif
);

    localparam int IDW_MIN = clog2_int(NREQ);

    generate
        if (IDW < IDW_MIN || NREQ < 2 || NREQ > 8) begin : g_bad_cfg
            $error("adder_rr_arbiter: NREQ must be 2..8 and 2**IDW >= NREQ");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_next;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_owner;
    logic            r_carry;
    logic            r_first;
    logic            w_pick_found;
    logic [IDW-1:0]  w_pick_idx;
    logic [IDW-1:0]  w_next_ptr;
    logic            w_accept;
    logic [NIB-1:0]  w_a;
    logic [NIB-1:0]  w_b;
    logic            w_cin;
    logic [NIB-1:0]  w_sum;
    logic            w_cout;

    rr_pick #(
        .NREQ   (NREQ),
        .IDW    (IDW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .found  (w_pick_found),
        .index  (w_pick_idx)
    );

    // A beat moves only when the output register is empty or being drained.
    assign w_accept  = (r_state == BUSY) && req[r_owner] && (!res_valid || res_ready);
    assign req_ready = w_accept ? (NREQ'(1) << r_owner) : '0;

    assign w_a   = req_a[r_owner*NIB +: NIB];
    assign w_b   = req_b[r_owner*NIB +: NIB];
    assign w_cin = r_first ? req_cin[r_owner] : r_carry;

    assign w_next_ptr = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    Ripple_Carry_Adder #(
        .WIDTH (NIB)
    ) u_adder (
        .a     (w_a),
        .b     (w_b),
        .cin   (w_cin),
        .sum   (w_sum),
        .cout  (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_found) w_state_next = BUSY;
            BUSY:    if (w_accept && req_last[r_owner]) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_carry   <= 1'b0;
            r_first   <= 1'b1;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= '0;
            res_last  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_pick_found) begin
                r_owner <= w_pick_idx;
            end
            if (w_accept) begin
                r_carry   <= w_cout;
                r_first   <= req_last[r_owner];
                res_valid <= 1'b1;
                res_sum   <= w_sum;
                res_cout  <= w_cout;
                res_id    <= r_owner;
                res_last  <= req_last[r_owner];
                if (req_last[r_owner]) begin
                    r_rr_ptr <= w_next_ptr;
                end
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ADDER_ARB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ovf <= 1'b0;
        end else if (w_accept) begin
            res_ovf <= req_last[r_owner] && (w_a[NIB-1] == w_b[NIB-1]) &&
                       (w_sum[NIB-1] != w_a[NIB-1]);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
// ============================================================================
// Module   : tb_adder_rr_arbiter
// Purpose  : Self-checking bench for adder_rr_arbiter against a
//            transaction-level arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adder_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_sum;
    logic              res_cout;
    logic [IDW-1:0]    res_id;
    logic              res_last;
`ifdef ADDER_ARB_OVF_EN
    logic              res_ovf;
`endif

    int total = 0;
    int bad   = 0;

    // Per-requester transaction: full-width operands, beat count, progress.
    int tx_act  [NREQ];
    int tx_beats[NREQ];
    int tx_idx  [NREQ];
    int tx_a    [NREQ];
    int tx_b    [NREQ];
    int tx_cin  [NREQ];

    bit m_busy;
    int m_owner;
    int m_ptr;
    bit e_valid;
    int e_sum, e_cout, e_id, e_last, e_ovf;
    int gap_pct = 0;
    int rdy_pct = 100;

    adder_rr_arbiter #(
        .NREQ      (NREQ),
        .IDW       (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .res_last  (res_last)
`ifdef ADDER_ARB_OVF_EN
       ,.res_ovf   (res_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        e_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) tx_act[i] = 0;
    endtask

    task automatic start_tx(input int i, input int beats, input int a, input int b, input int c);
        tx_act[i]   = 1;
        tx_beats[i] = beats;
        tx_idx[i]   = 0;
        tx_a[i]     = a & ((1 << (4*beats)) - 1);
        tx_b[i]     = b & ((1 << (4*beats)) - 1);
        tx_cin[i]   = c & 1;
    endtask

    // One clock: drive after the edge, check and advance the model at negedge.
    task automatic cycle();
        logic [NREQ-1:0] exp_rr;
        int  o, k, mask, low, an, bn;
        bit  old_busy;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            k = tx_idx[i];
            if (tx_act[i] != 0) begin
                req[i]          = ($urandom_range(99) >= gap_pct);
                req_a[4*i +: 4] = 4'((tx_a[i] >> (4*k)) & 15);
                req_b[4*i +: 4] = 4'((tx_b[i] >> (4*k)) & 15);
                req_cin[i]      = (k == 0) ? (tx_cin[i] != 0) : 1'($urandom_range(1));
                req_last[i]     = (k == tx_beats[i] - 1);
            end else begin
                req[i]          = 1'b0;
                req_a[4*i +: 4] = 4'($urandom);
                req_b[4*i +: 4] = 4'($urandom);
                req_cin[i]      = 1'($urandom_range(1));
                req_last[i]     = 1'($urandom_range(1));
            end
        end
        res_ready = ($urandom_range(99) < rdy_pct);
        @(negedge clk);
        exp_rr = '0;
        if (m_busy && req[m_owner] && (!e_valid || res_ready)) exp_rr[m_owner] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("onehot", 32'($countones(req_ready) <= 1), 1);
        chk("res_valid", 32'(res_valid), 32'(e_valid));
        if (e_valid) begin
            chk("res_sum", 32'(res_sum), e_sum);
            chk("res_cout", 32'(res_cout), e_cout);
            chk("res_id", 32'(res_id), e_id);
            chk("res_last", 32'(res_last), e_last);
`ifdef ADDER_ARB_OVF_EN
            chk("res_ovf", 32'(res_ovf), e_ovf);
`endif
        end
        old_busy = m_busy;
        if (old_busy && exp_rr != '0) begin
            // Beat k of a chained add is the k-th nibble of the full-width sum.
            o      = m_owner;
            k      = tx_idx[o];
            mask   = (1 << (4*(k+1))) - 1;
            low    = (tx_a[o] & mask) + (tx_b[o] & mask) + tx_cin[o];
            an     = (tx_a[o] >> (4*k)) & 15;
            bn     = (tx_b[o] >> (4*k)) & 15;
            e_sum  = (low >> (4*k)) & 15;
            e_cout = (low >> (4*(k+1))) & 1;
            e_id   = o;
            e_last = (k == tx_beats[o] - 1) ? 1 : 0;
            e_ovf  = (e_last == 1 && an[3] == bn[3] && e_sum[3] != an[3]) ? 1 : 0;
            e_valid = 1'b1;
            tx_idx[o]++;
            if (e_last == 1) begin
                tx_act[o] = 0;
                m_busy    = 1'b0;
                m_ptr     = (o + 1) % NREQ;
            end
        end else if (res_ready) begin
            e_valid = 1'b0;
        end
        if (!old_busy) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!m_busy && req[(m_ptr + j) % NREQ]) begin
                    m_owner = (m_ptr + j) % NREQ;
                    m_busy  = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        bit done;
        done    = 1'b0;
        rdy_pct = 100;
        gap_pct = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            cycle();
            done = !e_valid && !m_busy;
            for (int i = 0; i < NREQ; i++) if (tx_act[i] != 0) done = 1'b0;
        end
        chk("drain_done", 32'(done), 1);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_last  = '0;
        res_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_sum", 32'(res_sum), 0);
        chk("rst_id", 32'(res_id), 0);
        chk("rst_last", 32'(res_last), 0);
        chk("rst_cout", 32'(res_cout), 0);
        rst = 1'b0;

        // Two-beat carry chain on requester 0.
        start_tx(0, 2, 'h0F, 'h01, 0);
        drain();

        // All four single-beat, continuous draining.
        for (int i = 0; i < NREQ; i++)
            start_tx(i, 1, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
        drain();

        // Requester 2 locked while 1 and 3 wait.
        start_tx(2, 3, 'h9A5, 'h3C7, 1);
        cycle();
        cycle();
        start_tx(1, 1, 'h4, 'h5, 0);
        start_tx(3, 2, 'h77, 'h19, 0);
        drain();

        // Backpressure: hold the first result for 5 cycles.
        start_tx(0, 4, 'hBEEF, 'h1234, 1);
        rdy_pct = 0;
        for (int n = 0; n < 10 && !e_valid; n++) cycle();
        repeat (5) cycle();
        drain();

        // Async reset mid-transaction; the next first beat must use req_cin.
        start_tx(1, 3, 'hFFF, 'h0FF, 1);
        repeat (3) cycle();
        rst = 1'b1;
        req = '0;
        #1;
        chk("arst_valid", 32'(res_valid), 0);
        chk("arst_ready", 32'(req_ready), 0);
        chk("arst_sum", 32'(res_sum), 0);
        chk("arst_id", 32'(res_id), 0);
        chk("arst_last", 32'(res_last), 0);
        #2;
        rst = 1'b0;
        model_reset();
        start_tx(1, 1, 'h0, 'h0, 0);
        drain();

        // Signed-overflow corner beats.
        start_tx(0, 1, 'h7, 'h1, 0);
        drain();
        start_tx(0, 1, 'h8, 'hF, 0);
        drain();
        start_tx(0, 1, 'h3, 'h2, 0);
        drain();

        // Random traffic with request gaps and random backpressure.
        gap_pct = 15;
        rdy_pct = 75;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (tx_act[i] == 0 && $urandom_range(99) < 30)
                    start_tx(i, int'($urandom_range(1, 4)), int'($urandom), int'($urandom),
                             int'($urandom_range(1)));
            end
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
